// File: rtl/ic_rsp_sequencer.sv
// rtl/ic_rsp_sequencer.sv - in-order response sequencer with decode-error and protocol-error tracking
// Records each accepted request's target and grants responses strictly in request order.
module ic_rsp_sequencer #(
  parameter int ND    = 3,
  parameter int DEPTH = 4,
  localparam int CW   = $clog2(DEPTH + 1),
  localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          g_clk,
  input  logic          g_resetn,
  input  logic          req_valid,
  input  logic [ND-1:0] req_sel,
  output logic          req_ready,
  input  logic [ND-1:0] rsp_valid,
  output logic [ND-1:0] rsp_gnt,
  output logic          derr_valid,
  input  logic          derr_ack,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          err_unexp,
  output logic          err_sel
);

  logic [ND-1:0] buf_q [DEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [CW-1:0] count_q, count_d;
  logic          err_unexp_q, err_unexp_d;
  logic          err_sel_q, err_sel_d;

  logic          sel_ok;
  logic          push;
  logic          pop;
  logic [ND-1:0] sel_t;

  // zero (unmapped) or exactly one bit set
  assign sel_ok = ((req_sel & (req_sel - ND'(1))) == '0);

  assign empty      = (count_q == '0);
  assign full       = (count_q == CW'(DEPTH));
  assign req_ready  = !full;
  assign sel_t      = empty ? '0 : buf_q[tail_q];
  assign rsp_gnt    = sel_t;
  assign derr_valid = !empty && (sel_t == '0);
  assign count      = count_q;
  assign err_unexp  = err_unexp_q;
  assign err_sel    = err_sel_q;

  assign push = req_valid && req_ready && sel_ok;
  assign pop  = !empty && ((|(rsp_valid & sel_t)) || (derr_valid && derr_ack));

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    count_d     = count_q;
    err_unexp_d = err_unexp_q;
    err_sel_d   = err_sel_q;
    if (push) begin
      head_d = (head_q == PW'(DEPTH - 1)) ? '0 : head_q + PW'(1);
    end
    if (pop) begin
      tail_d = (tail_q == PW'(DEPTH - 1)) ? '0 : tail_q + PW'(1);
    end
    if (push && !pop) begin
      count_d = count_q + CW'(1);
    end else if (pop && !push) begin
      count_d = count_q - CW'(1);
    end
    // any response bit outside the granted device is a protocol violation
    if (|(rsp_valid & ~sel_t)) begin
      err_unexp_d = 1'b1;
    end
    if (req_valid && !sel_ok) begin
      err_sel_d = 1'b1;
    end
  end

  always_ff @(posedge g_clk) begin
    if (!g_resetn) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      err_unexp_q <= 1'b0;
      err_sel_q   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        buf_q[i] <= '0;
      end
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      err_unexp_q <= err_unexp_d;
      err_sel_q   <= err_sel_d;
      if (push) begin
        buf_q[head_q] <= req_sel;
      end
    end
  end

endmodule

// File: tb/tb_ic_rsp_sequencer.sv
// tb/tb_ic_rsp_sequencer.sv - directed self-checking bench for ic_rsp_sequencer
// Drives a DEPTH=4 instance for most scenarios and a DEPTH=3 instance for pointer wrap.
module tb_ic_rsp_sequencer;

  logic       g_clk = 1'b0;
  logic       g_resetn;
  int         checks = 0;
  int         failures = 0;

  logic       a_req_valid, a_req_ready, a_derr_valid, a_derr_ack;
  logic [2:0] a_req_sel, a_rsp_valid, a_rsp_gnt;
  logic [2:0] a_count;
  logic       a_empty, a_full, a_err_unexp, a_err_sel;

  logic       b_req_valid, b_req_ready, b_derr_valid, b_derr_ack;
  logic [2:0] b_req_sel, b_rsp_valid, b_rsp_gnt;
  logic [1:0] b_count;
  logic       b_empty, b_full, b_err_unexp, b_err_sel;

  always #5 g_clk = ~g_clk;

  ic_rsp_sequencer #(.ND(3), .DEPTH(4)) u_a (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(a_req_valid), .req_sel(a_req_sel), .req_ready(a_req_ready),
    .rsp_valid(a_rsp_valid), .rsp_gnt(a_rsp_gnt),
    .derr_valid(a_derr_valid), .derr_ack(a_derr_ack),
    .count(a_count), .empty(a_empty), .full(a_full),
    .err_unexp(a_err_unexp), .err_sel(a_err_sel)
  );

  ic_rsp_sequencer #(.ND(3), .DEPTH(3)) u_b (
    .g_clk(g_clk), .g_resetn(g_resetn),
    .req_valid(b_req_valid), .req_sel(b_req_sel), .req_ready(b_req_ready),
    .rsp_valid(b_rsp_valid), .rsp_gnt(b_rsp_gnt),
    .derr_valid(b_derr_valid), .derr_ack(b_derr_ack),
    .count(b_count), .empty(b_empty), .full(b_full),
    .err_unexp(b_err_unexp), .err_sel(b_err_sel)
  );

  task automatic cyc();
    @(posedge g_clk);
    #1;
  endtask

  task automatic idle_inputs();
    a_req_valid = 1'b0; a_req_sel = 3'b000; a_rsp_valid = 3'b000; a_derr_ack = 1'b0;
    b_req_valid = 1'b0; b_req_sel = 3'b000; b_rsp_valid = 3'b000; b_derr_ack = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    g_resetn = 1'b0;
    cyc();
    cyc();
    g_resetn = 1'b1;
  endtask

  task automatic push_a(input logic [2:0] sel);
    a_req_valid = 1'b1; a_req_sel = sel;
    cyc();
    a_req_valid = 1'b0; a_req_sel = 3'b000;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (a_req_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%0b exp=1", a_req_ready); end
    checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL reset_empty got=%0b exp=1", a_empty); end
    checks++; if (a_count !== 3'd0) begin failures++; $display("FAIL reset_count got=%0d exp=0", a_count); end
    checks++; if (a_rsp_gnt !== 3'b000) begin failures++; $display("FAIL reset_gnt got=%b exp=000", a_rsp_gnt); end
    checks++; if (a_full !== 1'b0 || a_derr_valid !== 1'b0) begin failures++; $display("FAIL reset_full_derr got=%0b%0b exp=00", a_full, a_derr_valid); end
    checks++; if (a_err_unexp !== 1'b0 || a_err_sel !== 1'b0) begin failures++; $display("FAIL reset_errs got=%0b%0b exp=00", a_err_unexp, a_err_sel); end
  endtask

  task automatic test_order_unexp();
    do_reset();
    push_a(3'b001); push_a(3'b010); push_a(3'b100);
    checks++; if (a_count !== 3'd3) begin failures++; $display("FAIL ord_count3 got=%0d exp=3", a_count); end
    checks++; if (a_rsp_gnt !== 3'b001) begin failures++; $display("FAIL ord_gnt0 got=%b exp=001", a_rsp_gnt); end
    a_rsp_valid = 3'b010; cyc(); a_rsp_valid = 3'b000;
    checks++; if (a_err_unexp !== 1'b1) begin failures++; $display("FAIL ord_unexp got=%0b exp=1", a_err_unexp); end
    checks++; if (a_count !== 3'd3) begin failures++; $display("FAIL ord_nopop got=%0d exp=3", a_count); end
    a_rsp_valid = 3'b001; cyc(); a_rsp_valid = 3'b000;
    checks++; if (a_rsp_gnt !== 3'b010) begin failures++; $display("FAIL ord_gnt1 got=%b exp=010", a_rsp_gnt); end
    checks++; if (a_count !== 3'd2) begin failures++; $display("FAIL ord_count2 got=%0d exp=2", a_count); end
    a_rsp_valid = 3'b010; cyc();
    a_rsp_valid = 3'b100; cyc(); a_rsp_valid = 3'b000;
    checks++; if (a_empty !== 1'b1 || a_err_unexp !== 1'b1) begin failures++; $display("FAIL ord_drain got=%0b%0b exp=11", a_empty, a_err_unexp); end
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < 4; i++) push_a(3'b001);
    checks++; if (a_full !== 1'b1 || a_req_ready !== 1'b0) begin failures++; $display("FAIL full_flags got=%0b%0b exp=10", a_full, a_req_ready); end
    a_req_valid = 1'b1; a_req_sel = 3'b010; cyc();
    checks++; if (a_count !== 3'd4) begin failures++; $display("FAIL full_nopush got=%0d exp=4", a_count); end
    a_rsp_valid = 3'b001; #1;
    checks++; if (a_req_ready !== 1'b0) begin failures++; $display("FAIL full_ready_pop got=%0b exp=0", a_req_ready); end
    cyc(); a_rsp_valid = 3'b000; a_req_valid = 1'b0;
    checks++; if (a_count !== 3'd3 || a_req_ready !== 1'b1) begin failures++; $display("FAIL full_after_pop got=%0d/%0b exp=3/1", a_count, a_req_ready); end
    checks++; if (a_rsp_gnt !== 3'b001) begin failures++; $display("FAIL full_gnt got=%b exp=001", a_rsp_gnt); end
  endtask

  task automatic test_wrap();
    logic [2:0] seq [7];
    seq[0] = 3'b001; seq[1] = 3'b010; seq[2] = 3'b100; seq[3] = 3'b001;
    seq[4] = 3'b100; seq[5] = 3'b010; seq[6] = 3'b001;
    do_reset();
    b_req_valid = 1'b1; b_req_sel = seq[0]; cyc();
    b_req_sel = seq[1]; cyc();
    for (int i = 2; i < 7; i++) begin
      b_req_sel = seq[i]; b_rsp_valid = seq[i-2]; #1;
      checks++; if (b_rsp_gnt !== seq[i-2]) begin failures++; $display("FAIL wrap_gnt%0d got=%b exp=%b", i-2, b_rsp_gnt, seq[i-2]); end
      cyc();
      checks++; if (b_count !== 2'd2) begin failures++; $display("FAIL wrap_count%0d got=%0d exp=2", i-2, b_count); end
    end
    b_req_valid = 1'b0; b_req_sel = 3'b000;
    for (int i = 5; i < 7; i++) begin
      b_rsp_valid = seq[i]; #1;
      checks++; if (b_rsp_gnt !== seq[i]) begin failures++; $display("FAIL wrap_gnt%0d got=%b exp=%b", i, b_rsp_gnt, seq[i]); end
      cyc();
    end
    b_rsp_valid = 3'b000;
    checks++; if (b_count !== 2'd0 || b_empty !== 1'b1) begin failures++; $display("FAIL wrap_end got=%0d/%0b exp=0/1", b_count, b_empty); end
    checks++; if (b_err_unexp !== 1'b0) begin failures++; $display("FAIL wrap_unexp got=%0b exp=0", b_err_unexp); end
  endtask

  task automatic test_derr();
    do_reset();
    push_a(3'b000); push_a(3'b100);
    checks++; if (a_derr_valid !== 1'b1 || a_rsp_gnt !== 3'b000) begin failures++; $display("FAIL derr_head got=%0b/%b exp=1/000", a_derr_valid, a_rsp_gnt); end
    a_derr_ack = 1'b1; cyc();
    checks++; if (a_rsp_gnt !== 3'b100 || a_derr_valid !== 1'b0) begin failures++; $display("FAIL derr_pop got=%b/%0b exp=100/0", a_rsp_gnt, a_derr_valid); end
    cyc(); a_derr_ack = 1'b0;
    checks++; if (a_count !== 3'd1) begin failures++; $display("FAIL derr_ack_ignored got=%0d exp=1", a_count); end
    a_rsp_valid = 3'b100; cyc(); a_rsp_valid = 3'b000;
    checks++; if (a_empty !== 1'b1) begin failures++; $display("FAIL derr_drain got=%0b exp=1", a_empty); end
  endtask

  task automatic test_back_to_back();
    do_reset();
    a_req_valid = 1'b1; a_req_sel = 3'b011; cyc(); a_req_valid = 1'b0;
    checks++; if (a_err_sel !== 1'b1 || a_count !== 3'd0) begin failures++; $display("FAIL sel_multi got=%0b/%0d exp=1/0", a_err_sel, a_count); end
    push_a(3'b001); push_a(3'b010);
    a_req_valid = 1'b1; a_req_sel = 3'b100; a_rsp_valid = 3'b001; cyc();
    idle_inputs();
    checks++; if (a_count !== 3'd2 || a_rsp_gnt !== 3'b010) begin failures++; $display("FAIL pushpop got=%0d/%b exp=2/010", a_count, a_rsp_gnt); end
    checks++; if (a_err_sel !== 1'b1 || a_err_unexp !== 1'b0) begin failures++; $display("FAIL sticky got=%0b%0b exp=10", a_err_sel, a_err_unexp); end
    g_resetn = 1'b0; cyc(); g_resetn = 1'b1;
    checks++; if (a_count !== 3'd0 || a_empty !== 1'b1 || a_rsp_gnt !== 3'b000) begin failures++; $display("FAIL midreset got=%0d/%0b/%b exp=0/1/000", a_count, a_empty, a_rsp_gnt); end
    checks++; if (a_err_sel !== 1'b0) begin failures++; $display("FAIL midreset_errsel got=%0b exp=0", a_err_sel); end
    a_req_valid = 1'b1; a_req_sel = 3'b001; a_rsp_valid = 3'b001; cyc();
    idle_inputs();
    checks++; if (a_count !== 3'd1 || a_err_unexp !== 1'b1) begin failures++; $display("FAIL nobypass got=%0d/%0b exp=1/1", a_count, a_err_unexp); end
    checks++; if (a_rsp_gnt !== 3'b001) begin failures++; $display("FAIL nobypass_gnt got=%b exp=001", a_rsp_gnt); end
  endtask

  initial begin
    g_resetn = 1'b0;
    idle_inputs();
    test_reset();
    test_order_unexp();
    test_full();
    test_wrap();
    test_derr();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
